burst_write_dma: RTL and testbench
==================================

Name: burst_write_dma

Overview:
- DMA engine that copies a fixed-size block from an asynchronous word-addressed memory (read side, e.g. BRAM or line buffer) to a burst-oriented memory (write side, e.g. DDR or SDRAM port).
- Counterpart of the burst read DMA: reads single words, buffers them in a FIFO, and emits fixed-length write bursts.
- Used to flush frame and sprite buffers to external memory.

Parameters:
- ADDR_WIDTH, 32, width of both address buses.
- DATA_WIDTH, 64, word width. Byte address step is DATA_WIDTH/8.
- NUM_WORDS, 128, words per transfer. Power of two, multiple of BURST_LENGTH.
- BURST_LENGTH, 16, words per write burst. Power of two, ≥2.
- FIFO_DEPTH, 32, buffer words. Must be ≥ 2*BURST_LENGTH.

Ports:
- clock  in  1  sole clock.
- reset  in  1  synchronous, active-low reset (asserted when 0).
- io_start  in  1  starts a transfer; ignored while busy.
- io_busy  out  1  transfer in progress.
- io_done  out  1  one-cycle pulse when the last burst completes.
- io_in_rd  out  1  read request.
- io_in_addr  out  ADDR_WIDTH  read byte address.
- io_in_dout  in  DATA_WIDTH  read data.
- io_in_wait_n  in  1  read request accepted when high.
- io_in_valid  in  1  read data valid.
- io_out_wr  out  1  write beat request.
- io_out_addr  out  ADDR_WIDTH  burst start byte address.
- io_out_din  out  DATA_WIDTH  write data.
- io_out_wait_n  in  1  write beat accepted when high.
- io_out_burstDone  in  1  burst fully committed.

Behaviour:
- Reset (reset==0 at clock edge): all outputs 0, all counters 0, FIFO empty, FSM in IDLE. Reset mid-transfer abandons the transfer; no io_done pulse.
- Start: io_start && !io_busy flushes the FIFO, clears counters and pending count, and sets io_busy the next cycle.
- Read side:
  - io_in_rd = readEn && (fifo_count + pending) < FIFO_DEPTH.
  - Accept = io_in_rd && io_in_wait_n. Each accept increments readWord (log2 NUM_WORDS + 1 bits) and pending.
  - io_in_valid pushes io_in_dout into the FIFO and decrements pending. Simultaneous accept and valid leaves pending unchanged.
  - io_in_addr = readWord*(DATA_WIDTH/8), zero-extended.
  - readEn clears after the NUM_WORDS-th accept.
  - io_in_valid while pending==0 is ignored (not pushed).
- Write FSM:
  - IDLE: wait for start, then go to FILL.
  - FILL: io_out_wr=0. Go to BURST when fifo_count ≥ BURST_LENGTH, so a burst never starves.
  - BURST: io_out_wr=1 and io_out_din = FIFO head.
    - Beat accept = io_out_wr && io_out_wait_n: pops the FIFO and increments beat.
    - After the BURST_LENGTH-th accept, io_out_wr drops the next cycle and the FSM goes to WAIT_DONE.
  - WAIT_DONE: on io_out_burstDone, increment burstIdx.
    - If last burst: go to IDLE, pulse io_done, clear io_busy the same cycle.
    - Otherwise: go to FILL.
  - io_out_burstDone arriving in the same cycle as the final beat accept is honoured; the FSM skips WAIT_DONE.
  - io_out_burstDone in IDLE or FILL is ignored.
- io_out_addr = burstIdx*BURST_LENGTH*(DATA_WIDTH/8). Constant for a whole burst.
- Arithmetic: all counters wrap modulo their width; no saturation.
- Latency: first io_in_rd the cycle after start. First io_out_wr no sooner than one cycle after the BURST_LENGTH-th push.

Optional Feature:
- BURST_WRITE_DMA_WORD_SWAP_EN defined: io_out_din has its upper and lower DATA_WIDTH/2 halves swapped, for endian conversion. FIFO contents are unchanged.
- Undefined: io_out_din = FIFO head, unmodified.

Decomposition:
- Package burst_dma_pkg:
  - write-FSM state enum (IDLE, FILL, BURST, WAIT_DONE);
  - clog2-derived counter widths;
  - BYTES_PER_WORD constant.
- One sub-module: burst_dma_fifo, a synchronous show-ahead FIFO.
  - Parameters: DATA_WIDTH, DEPTH.
  - Ports: enq_valid, enq_bits, deq_ready, deq_valid, deq_bits, count, flush.

Test Plan:
- Ideal: wait_n=1 on both sides, io_in_valid one cycle after accept, start pulse → 8 bursts at io_out_addr 0x000, 0x080, …, 0x380; 128 beats with data matching source order; exactly one io_done pulse; io_busy low afterwards.
- Read stalls: io_in_wait_n=0 for 5 cycles every 3rd request → io_in_addr held during the stall, no duplicate or skipped words, output data identical to the ideal run.
- Write backpressure: io_out_wait_n toggling 50% and burstDone 10 cycles after the last beat → io_in_rd deasserts once fifo_count + pending = 32, no FIFO overflow, io_out_addr constant within each burst.
- Simultaneous events: burstDone in the same cycle as the 16th beat accept → FSM skips WAIT_DONE, burstIdx increments once; io_start during busy → no effect.
- Reset: drive reset=0 during burst 3 → all outputs 0 next cycle, no io_done; a fresh start then completes a full 128-word transfer.
- Swap (macro defined): source word 0x0011223344556677 → io_out_din 0x4455667700112233.

Source files
------------

// File: rtl/burst_dma_pkg.sv
// burst_dma_pkg
// Shared definitions for the burst DMA engines: the write-side FSM state
// type, default geometry, the byte step per word and helpers that derive
// counter widths from the module parameters.
// No ports (package).

package burst_dma_pkg;

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    FILL      = 2'd1,
    BURST     = 2'd2,
    WAIT_DONE = 2'd3
  } wr_state_t;

  localparam int DEFAULT_ADDR_WIDTH   = 32;
  localparam int DEFAULT_DATA_WIDTH   = 64;
  localparam int DEFAULT_NUM_WORDS    = 128;
  localparam int DEFAULT_BURST_LENGTH = 16;
  localparam int DEFAULT_FIFO_DEPTH   = 32;

  localparam int BYTES_PER_WORD = DEFAULT_DATA_WIDTH / 8;

  function automatic int bytes_per_word(input int data_width);
    return data_width / 8;
  endfunction

  // One extra bit so a counter can hold the terminal value n itself.
  function automatic int count_width(input int n);
    return $clog2(n) + 1;
  endfunction

endpackage

// File: rtl/burst_dma_fifo.sv
// burst_dma_fifo
// Synchronous show-ahead FIFO: deq_bits always presents the oldest entry
// while deq_valid is high, and is consumed by deq_ready.
// Ports:
//   clock, reset      sole clock, synchronous active-low reset
//   flush             empties the FIFO (wins over enqueue/dequeue)
//   enq_valid/bits    write side; ignored when full unless a dequeue frees a slot
//   deq_ready         pops the head entry when the FIFO is not empty
//   deq_valid/bits    head entry
//   count             number of stored entries (0..DEPTH)

module burst_dma_fifo
  import burst_dma_pkg::*;
#(
  parameter int DATA_WIDTH = DEFAULT_DATA_WIDTH,
  parameter int DEPTH      = DEFAULT_FIFO_DEPTH
) (
  input  logic                   clock,
  input  logic                   reset,
  input  logic                   flush,
  input  logic                   enq_valid,
  input  logic [DATA_WIDTH-1:0]  enq_bits,
  input  logic                   deq_ready,
  output logic                   deq_valid,
  output logic [DATA_WIDTH-1:0]  deq_bits,
  output logic [$clog2(DEPTH):0] count
);

  localparam int PTR_W = $clog2(DEPTH);

  logic [DATA_WIDTH-1:0] mem [DEPTH];
  logic [PTR_W-1:0]      wr_ptr;
  logic [PTR_W-1:0]      rd_ptr;
  logic                  do_enq;
  logic                  do_deq;

  assign deq_valid = (count != '0);
  assign deq_bits  = mem[rd_ptr];
  assign do_deq    = deq_ready && deq_valid;
  assign do_enq    = enq_valid && ((count != (PTR_W + 1)'(DEPTH)) || do_deq);

  // Pointers wrap explicitly so DEPTH need not be a power of two.
  always_ff @(posedge clock) begin
    if (!reset || flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_enq) begin
        wr_ptr <= (wr_ptr == PTR_W'(DEPTH - 1)) ? '0 : wr_ptr + PTR_W'(1);
      end
      if (do_deq) begin
        rd_ptr <= (rd_ptr == PTR_W'(DEPTH - 1)) ? '0 : rd_ptr + PTR_W'(1);
      end
      if (do_enq && !do_deq) begin
        count <= count + (PTR_W + 1)'(1);
      end else if (do_deq && !do_enq) begin
        count <= count - (PTR_W + 1)'(1);
      end
    end
  end

  // Storage carries no reset; stale entries are never visible because
  // deq_valid depends only on count.
  always_ff @(posedge clock) begin
    if (reset && !flush && do_enq) begin
      mem[wr_ptr] <= enq_bits;
    end
  end

endmodule

// File: rtl/burst_write_dma.sv
// burst_write_dma
// Copies NUM_WORDS words from an asynchronous word-addressed source into a
// burst-oriented sink. Single-word reads are buffered in a FIFO and drained
// as fixed BURST_LENGTH write bursts.
// Ports:
//   clock, reset                  sole clock, synchronous active-low reset
//   io_start                      starts a transfer (ignored while busy)
//   io_busy, io_done              transfer in progress / one-cycle completion pulse
//   io_in_rd, io_in_addr          read request and byte address
//   io_in_dout, io_in_wait_n      read data / request accepted when high
//   io_in_valid                   read data valid
//   io_out_wr, io_out_addr        write beat request / burst start byte address
//   io_out_din                    write data
//   io_out_wait_n                 beat accepted when high
//   io_out_burstDone              burst fully committed by the sink
// Build option: define BURST_WRITE_DMA_WORD_SWAP_EN to swap the upper and
// lower halves of every written word (endian conversion).

module burst_write_dma
  import burst_dma_pkg::*;
#(
  parameter int ADDR_WIDTH   = DEFAULT_ADDR_WIDTH,
  parameter int DATA_WIDTH   = DEFAULT_DATA_WIDTH,
  parameter int NUM_WORDS    = DEFAULT_NUM_WORDS,
  parameter int BURST_LENGTH = DEFAULT_BURST_LENGTH,
  parameter int FIFO_DEPTH   = DEFAULT_FIFO_DEPTH
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic                  io_start,
  output logic                  io_busy,
  output logic                  io_done,
  output logic                  io_in_rd,
  output logic [ADDR_WIDTH-1:0] io_in_addr,
  input  logic [DATA_WIDTH-1:0] io_in_dout,
  input  logic                  io_in_wait_n,
  input  logic                  io_in_valid,
  output logic                  io_out_wr,
  output logic [ADDR_WIDTH-1:0] io_out_addr,
  output logic [DATA_WIDTH-1:0] io_out_din,
  input  logic                  io_out_wait_n,
  input  logic                  io_out_burstDone
);

  localparam int BPW        = bytes_per_word(DATA_WIDTH);
  localparam int NUM_BURSTS = NUM_WORDS / BURST_LENGTH;
  localparam int RW_W       = count_width(NUM_WORDS);
  localparam int BI_W       = count_width(NUM_BURSTS);
  localparam int BEAT_W     = $clog2(BURST_LENGTH);
  localparam int CNT_W      = count_width(FIFO_DEPTH);

  wr_state_t             state;
  logic                  busy;
  logic                  done;
  logic                  read_en;
  logic [RW_W-1:0]       read_word;
  logic [CNT_W-1:0]      pending;
  logic [CNT_W-1:0]      fifo_count;
  logic [CNT_W:0]        in_flight;
  logic [BEAT_W-1:0]     beat;
  logic [BI_W-1:0]       burst_idx;
  logic                  fifo_valid;
  logic [DATA_WIDTH-1:0] fifo_head;

  logic start_fire;
  logic rd_req;
  logic read_accept;
  logic push;
  logic wr_req;
  logic beat_accept;
  logic last_beat;
  logic last_burst;
  logic burst_closing;

  assign start_fire  = io_start && !busy;
  // Words already buffered plus words requested but not yet returned must
  // never exceed the FIFO, so every returning word has a slot.
  assign in_flight   = {1'b0, fifo_count} + {1'b0, pending};
  assign rd_req      = read_en && (in_flight < (CNT_W + 1)'(FIFO_DEPTH));
  assign read_accept = rd_req && io_in_wait_n;
  // Data with nothing outstanding is stray and is dropped.
  assign push        = io_in_valid && (pending != '0);

  assign wr_req        = (state == BURST) && fifo_valid;
  assign beat_accept   = wr_req && io_out_wait_n;
  assign last_beat     = beat_accept && (beat == BEAT_W'(BURST_LENGTH - 1));
  assign last_burst    = (burst_idx == BI_W'(NUM_BURSTS - 1));
  // A completion arriving with the final beat closes the burst directly.
  assign burst_closing = ((state == WAIT_DONE) || last_beat) && io_out_burstDone;

  burst_dma_fifo #(
    .DATA_WIDTH (DATA_WIDTH),
    .DEPTH      (FIFO_DEPTH)
  ) u_fifo (
    .clock     (clock),
    .reset     (reset),
    .flush     (start_fire),
    .enq_valid (push),
    .enq_bits  (io_in_dout),
    .deq_ready (beat_accept),
    .deq_valid (fifo_valid),
    .deq_bits  (fifo_head),
    .count     (fifo_count)
  );

  // Read side: request address sequencing and outstanding-request count.
  always_ff @(posedge clock) begin
    if (!reset) begin
      read_en   <= 1'b0;
      read_word <= '0;
      pending   <= '0;
    end else if (start_fire) begin
      read_en   <= 1'b1;
      read_word <= '0;
      pending   <= '0;
    end else begin
      if (read_accept) begin
        read_word <= read_word + RW_W'(1);
        if (read_word == RW_W'(NUM_WORDS - 1)) begin
          read_en <= 1'b0;
        end
      end
      if (read_accept && !push) begin
        pending <= pending + CNT_W'(1);
      end else if (push && !read_accept) begin
        pending <= pending - CNT_W'(1);
      end
    end
  end

  // Write side: a burst starts only once a full burst is buffered, so the
  // sink is never starved mid-burst.
  always_ff @(posedge clock) begin
    if (!reset) begin
      state     <= IDLE;
      busy      <= 1'b0;
      done      <= 1'b0;
      beat      <= '0;
      burst_idx <= '0;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: begin
          if (start_fire) begin
            state     <= FILL;
            busy      <= 1'b1;
            beat      <= '0;
            burst_idx <= '0;
          end
        end
        FILL: begin
          if (fifo_count >= CNT_W'(BURST_LENGTH)) begin
            state <= BURST;
          end
        end
        BURST: begin
          if (beat_accept) begin
            beat <= beat + BEAT_W'(1);
          end
          if (last_beat && !io_out_burstDone) begin
            state <= WAIT_DONE;
          end
        end
        WAIT_DONE: begin
        end
        default: state <= IDLE;
      endcase

      if (burst_closing) begin
        burst_idx <= burst_idx + BI_W'(1);
        if (last_burst) begin
          state <= IDLE;
          busy  <= 1'b0;
          done  <= 1'b1;
        end else begin
          state <= FILL;
        end
      end
    end
  end

  assign io_busy     = busy;
  assign io_done     = done;
  assign io_in_rd    = rd_req;
  assign io_in_addr  = ADDR_WIDTH'(read_word) * ADDR_WIDTH'(BPW);
  assign io_out_wr   = wr_req;
  assign io_out_addr = ADDR_WIDTH'(burst_idx) * ADDR_WIDTH'(BURST_LENGTH * BPW);

`ifdef BURST_WRITE_DMA_WORD_SWAP_EN
  assign io_out_din = wr_req ? {fifo_head[DATA_WIDTH/2-1:0], fifo_head[DATA_WIDTH-1:DATA_WIDTH/2]}
                             : '0;
`else
  assign io_out_din = wr_req ? fifo_head : '0;
`endif

endmodule

// File: tb/tb_burst_write_dma.sv
// tb_burst_write_dma
// Directed bench for burst_write_dma: a source memory and burst sink are
// modelled on the falling edge; each scenario task starts a transfer and
// checks addresses, data order, request window and completion.

module tb_burst_write_dma;

  localparam int NW    = 128;
  localparam int BL    = 16;
  localparam int DEPTH = 32;

  logic        clock = 1'b0;
  logic        reset = 1'b0;
  logic        io_start = 1'b0;
  logic        io_busy;
  logic        io_done;
  logic        io_in_rd;
  logic [31:0] io_in_addr;
  logic [63:0] io_in_dout = '0;
  logic        io_in_wait_n = 1'b1;
  logic        io_in_valid = 1'b0;
  logic        io_out_wr;
  logic [31:0] io_out_addr;
  logic [63:0] io_out_din;
  logic        io_out_wait_n = 1'b1;
  logic        io_out_burstDone = 1'b0;

  int assertions = 0;
  int failures   = 0;

  bit   active = 0;
  bit   checkRd = 0;
  bit   rdStallMode = 0;
  bit   bpMode = 0;
  int   doneDelay = 1;
  int   rdAccepted = 0;
  int   popped = 0;
  int   doneCount = 0;
  int   stallLeft = 0;
  int   doneTimer = 0;
  bit   stallDone = 0;
  bit   toggle = 0;
  bit   postDoneCheck = 0;
  logic expRd;
  logic [31:0] stallAddr;
  logic [63:0] firstBeat;
  int   q[$];

  burst_write_dma dut (
    .clock            (clock),
    .reset            (reset),
    .io_start         (io_start),
    .io_busy          (io_busy),
    .io_done          (io_done),
    .io_in_rd         (io_in_rd),
    .io_in_addr       (io_in_addr),
    .io_in_dout       (io_in_dout),
    .io_in_wait_n     (io_in_wait_n),
    .io_in_valid      (io_in_valid),
    .io_out_wr        (io_out_wr),
    .io_out_addr      (io_out_addr),
    .io_out_din       (io_out_din),
    .io_out_wait_n    (io_out_wait_n),
    .io_out_burstDone (io_out_burstDone)
  );

  always #5 clock = ~clock;

  function automatic logic [63:0] src(input int i);
    return 64'h0011223344556677 + {32'(i), 32'(i)};
  endfunction

  function automatic logic [63:0] expOut(input int i);
    logic [63:0] w;
    w = src(i);
`ifdef BURST_WRITE_DMA_WORD_SWAP_EN
    return {w[31:0], w[63:32]};
`else
    return w;
`endif
  endfunction

  // Source memory and burst sink models; decisions are made on the falling
  // edge and take effect at the following rising edge.
  always @(negedge clock) begin
    if (!active) begin
      io_in_valid      = 1'b0;
      io_in_wait_n     = 1'b1;
      io_out_wait_n    = 1'b1;
      io_out_burstDone = 1'b0;
    end else begin
      if (checkRd) begin
        expRd = (rdAccepted < NW) && ((rdAccepted - popped) < DEPTH);
        assertions++;
        if (io_in_rd !== expRd) begin
          failures++;
          $display("[TB] FAIL rd_window: io_in_rd=%b expected %b (accepted=%0d popped=%0d)",
                   io_in_rd, expRd, rdAccepted, popped);
        end
      end
      if (io_done === 1'b1) begin
        doneCount++;
        assertions++;
        if (io_busy !== 1'b0) begin
          failures++;
          $display("[TB] FAIL done_busy: io_busy=%b expected 0 with io_done", io_busy);
        end
      end
      if (postDoneCheck) begin
        postDoneCheck = 0;
        assertions++;
        if (popped < NW) begin
          if (io_out_wr !== 1'b0 || io_out_addr !== 32'((popped / BL) * BL * 8)) begin
            failures++;
            $display("[TB] FAIL burst_advance: wr=%b addr=%h expected wr=0 addr=%h",
                     io_out_wr, io_out_addr, 32'((popped / BL) * BL * 8));
          end
        end else if (io_done !== 1'b1 || io_busy !== 1'b0) begin
          failures++;
          $display("[TB] FAIL last_done: done=%b busy=%b expected done=1 busy=0", io_done, io_busy);
        end
      end

      io_out_burstDone = 1'b0;
      if (doneTimer > 0) begin
        doneTimer--;
        if (doneTimer == 0) begin
          io_out_burstDone = 1'b1;
          postDoneCheck = 1;
        end
      end

      if (q.size() > 0) begin
        io_in_valid = 1'b1;
        io_in_dout  = src(q.pop_front());
      end else begin
        io_in_valid = 1'b0;
      end

      io_in_wait_n = 1'b1;
      if (io_in_rd === 1'b1) begin
        if (rdStallMode && stallLeft == 0 && !stallDone && (rdAccepted % 3) == 2) begin
          stallLeft = 5;
          stallAddr = io_in_addr;
          stallDone = 1;
        end
        if (stallLeft > 0) begin
          io_in_wait_n = 1'b0;
          stallLeft--;
          assertions++;
          if (io_in_addr !== stallAddr) begin
            failures++;
            $display("[TB] FAIL stall_addr: io_in_addr=%h expected %h", io_in_addr, stallAddr);
          end
        end else begin
          assertions++;
          if (io_in_addr !== 32'(rdAccepted * 8)) begin
            failures++;
            $display("[TB] FAIL rd_addr: io_in_addr=%h expected %h", io_in_addr, 32'(rdAccepted * 8));
          end
          q.push_back(rdAccepted);
          rdAccepted++;
          stallDone = 0;
        end
      end

      io_out_wait_n = bpMode ? toggle : 1'b1;
      toggle = !toggle;
      if (io_out_wr === 1'b1) begin
        assertions++;
        if (popped >= NW) begin
          failures++;
          $display("[TB] FAIL extra_beat: io_out_wr=1 expected 0 after %0d beats", popped);
        end else if (io_out_addr !== 32'((popped / BL) * BL * 8)) begin
          failures++;
          $display("[TB] FAIL wr_addr: io_out_addr=%h expected %h", io_out_addr, 32'((popped / BL) * BL * 8));
        end
        if (io_out_wait_n && popped < NW) begin
          assertions++;
          if (io_out_din !== expOut(popped)) begin
            failures++;
            $display("[TB] FAIL wr_data: beat %0d io_out_din=%h expected %h", popped, io_out_din, expOut(popped));
          end
          if (popped == 0) firstBeat = io_out_din;
          popped++;
          if (popped % BL == 0) begin
            if (doneDelay == 0) begin
              io_out_burstDone = 1'b1;
              postDoneCheck = 1;
            end else begin
              doneTimer = doneDelay;
            end
          end
        end
      end
    end
  end

  task automatic applyStimulus();
    @(posedge clock); #1;
    checkRd = 0;
    rdAccepted = 0; popped = 0; doneCount = 0; stallLeft = 0; stallDone = 0;
    doneTimer = 0; postDoneCheck = 0; toggle = 0; firstBeat = '0;
    q.delete();
    active = 1;
    io_start = 1'b1;
    @(posedge clock); #1;
    io_start = 1'b0;
    checkRd = 1;
    assertions++;
    if (io_busy !== 1'b1) begin
      failures++;
      $display("[TB] FAIL busy_after_start: io_busy=%b expected 1", io_busy);
    end
  endtask

  task automatic checkOutput(input string name, input int limit);
    int n;
    n = 0;
    while (!(popped == NW && doneCount >= 1) && n < limit) begin
      @(posedge clock);
      n++;
    end
    repeat (3) @(posedge clock);
    #1;
    checkRd = 0;
    assertions++;
    if (n >= limit) begin
      failures++;
      $display("[TB] FAIL %s_timeout: popped=%0d done=%0d expected %0d beats and one done", name, popped, doneCount, NW);
    end
    assertions++;
    if (doneCount !== 1) begin
      failures++;
      $display("[TB] FAIL %s_done_count: got %0d expected 1", name, doneCount);
    end
    assertions++;
    if (io_busy !== 1'b0 || rdAccepted !== NW) begin
      failures++;
      $display("[TB] FAIL %s_idle: busy=%b reads=%0d expected busy=0 reads=%0d", name, io_busy, rdAccepted, NW);
    end
  endtask

  task automatic waitBeats(input int target);
    int n;
    n = 0;
    while (popped < target && n < 2000) begin
      @(posedge clock);
      n++;
    end
    assertions++;
    if (popped < target) begin
      failures++;
      $display("[TB] FAIL wait_beats: popped=%0d expected at least %0d", popped, target);
    end
  endtask

  task automatic checkAllZero(input string name);
    assertions++;
    if ({io_busy, io_done, io_in_rd, io_out_wr} !== 4'b0 || io_in_addr !== '0 ||
        io_out_addr !== '0 || io_out_din !== '0) begin
      failures++;
      $display("[TB] FAIL %s: busy=%b done=%b rd=%b wr=%b in_addr=%h out_addr=%h din=%h expected all 0",
               name, io_busy, io_done, io_in_rd, io_out_wr, io_in_addr, io_out_addr, io_out_din);
    end
  endtask

  task automatic test_reset();
    reset = 1'b0;
    repeat (3) @(posedge clock);
    #1;
    checkAllZero("reset_state");
    reset = 1'b1;
    repeat (2) @(posedge clock);
    #1;
    checkAllZero("idle_after_reset");
  endtask

  task automatic test_ideal();
    logic [63:0] expFirst;
`ifdef BURST_WRITE_DMA_WORD_SWAP_EN
    expFirst = 64'h4455667700112233;
`else
    expFirst = 64'h0011223344556677;
`endif
    rdStallMode = 0; bpMode = 0; doneDelay = 1;
    applyStimulus();
    checkOutput("ideal", 3000);
    assertions++;
    if (firstBeat !== expFirst) begin
      failures++;
      $display("[TB] FAIL first_word: io_out_din=%h expected %h", firstBeat, expFirst);
    end
  endtask

  task automatic test_read_stalls();
    rdStallMode = 1; bpMode = 0; doneDelay = 1;
    applyStimulus();
    checkOutput("read_stalls", 3000);
    rdStallMode = 0;
  endtask

  task automatic test_backpressure();
    rdStallMode = 0; bpMode = 1; doneDelay = 10;
    applyStimulus();
    checkOutput("backpressure", 4000);
    bpMode = 0;
  endtask

  task automatic test_simultaneous();
    rdStallMode = 0; bpMode = 0; doneDelay = 0;
    applyStimulus();
    waitBeats(20);
    @(posedge clock); #1;
    io_start = 1'b1;
    @(posedge clock); #1;
    io_start = 1'b0;
    assertions++;
    if (io_busy !== 1'b1) begin
      failures++;
      $display("[TB] FAIL start_while_busy: io_busy=%b expected 1", io_busy);
    end
    checkOutput("simultaneous", 3000);
    doneDelay = 1;
  endtask

  task automatic test_reset_mid();
    rdStallMode = 0; bpMode = 0; doneDelay = 1;
    applyStimulus();
    waitBeats(2 * BL + 3);
    @(posedge clock); #1;
    reset = 1'b0;
    active = 0;
    checkRd = 0;
    @(posedge clock); #1;
    checkAllZero("reset_mid");
    repeat (3) begin
      @(posedge clock); #1;
      assertions++;
      if (io_done !== 1'b0 || io_busy !== 1'b0) begin
        failures++;
        $display("[TB] FAIL reset_no_done: done=%b busy=%b expected 0", io_done, io_busy);
      end
      reset = 1'b1;
    end
    applyStimulus();
    checkOutput("after_reset", 3000);
  endtask

  initial begin
    test_reset();
    test_ideal();
    test_read_stalls();
    test_backpressure();
    test_simultaneous();
    test_reset_mid();
    $display("End of test - %0d assertions evaluated, %0d failures", assertions, failures);
    $finish;
  end

endmodule
